// File: rtl/bus_pkg.sv
// bus_pkg: shared constants for the two-master bus arbiter (state codes, master ids, widths).
// Revision 1.0
`default_nettype none

package bus_pkg;

  localparam int AW_DEFAULT = 16;
  localparam int DW_DEFAULT = 16;
  localparam int HOLD_W     = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] own_state(input logic idx);
    return (idx == M1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_hold_counter.sv
// arb_hold_counter: saturating owned-cycle counter; expired flags the last allowed cycle.
// Revision 1.0
`default_nettype none

module arb_hold_counter
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic owned,
  input  logic restart,
  output logic expired
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // restart wins over counting so every new owner starts from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (restart) begin
      hold_cnt <= '0;
    end else if (owned && (hold_cnt != {HOLD_W{1'b1}})) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign expired = owned && (hold_cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter and bus mux in front of memory_map.
// Optional hold-limit preemption enabled by ARB_HOLD_LIMIT_EN. Revision 1.0
`default_nettype none

module bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter int DW       = DW_DEFAULT,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_din,
  input  logic          m0_we,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_dout,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_din,
  input  logic          m1_we,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_dout,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last;
  logic       last_nxt;
  logic       other_req;
  logic       preempt;

  assign other_req = (state == ST_OWN0) ? m1_req : m0_req;

`ifdef ARB_HOLD_LIMIT_EN
  logic hold_expired;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .owned   (state != ST_IDLE),
    .restart (state_nxt != state),
    .expired (hold_expired)
  );

  assign preempt = hold_expired && other_req;
`else
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);
  logic unused_hold;

  assign unused_hold = ^HOLD_LIMIT;
  assign preempt     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          state_nxt = own_state(~last);
        end else if (m0_req) begin
          state_nxt = ST_OWN0;
        end else if (m1_req) begin
          state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_req) begin
          state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
          last_nxt  = M0;
        end else if (preempt) begin
          state_nxt = ST_OWN1;
          last_nxt  = M0;
        end
      end
      ST_OWN1: begin
        if (!m1_req) begin
          state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
          last_nxt  = M1;
        end else if (preempt) begin
          state_nxt = ST_OWN0;
          last_nxt  = M1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // last resets to master 1 so master 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      last  <= M1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  assign m0_gnt = (state == ST_OWN0);
  assign m1_gnt = (state == ST_OWN1);

  // a master that has dropped req can no longer write, even with we still high
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    case (state)
      ST_OWN0: begin
        mem_addr = m0_addr;
        mem_din  = m0_din;
        mem_we   = m0_we & m0_req & m0_gnt;
      end
      ST_OWN1: begin
        mem_addr = m1_addr;
        mem_din  = m1_din;
        mem_we   = m1_we & m1_req & m1_gnt;
      end
      default: begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
      end
    endcase
  end

  assign m0_dout = mem_dout;
  assign m1_dout = mem_dout;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter with a small memory model.
`default_nettype none

module tb_bus_arbiter;
  import bus_pkg::*;

  logic        clk;
  logic        reset;
  logic        m0_req;
  logic [15:0] m0_addr;
  logic [15:0] m0_din;
  logic        m0_we;
  logic        m0_gnt;
  logic [15:0] m0_dout;
  logic        m1_req;
  logic [15:0] m1_addr;
  logic [15:0] m1_din;
  logic        m1_we;
  logic        m1_gnt;
  logic [15:0] m1_dout;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout;

  logic [15:0] mem [0:255];

  int total;
  int bad;
  int n;

  bus_arbiter #(
    .AW       (16),
    .DW       (16),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_din   (m0_din),
    .m0_we    (m0_we),
    .m0_gnt   (m0_gnt),
    .m0_dout  (m0_dout),
    .m1_req   (m1_req),
    .m1_addr  (m1_addr),
    .m1_din   (m1_din),
    .m1_we    (m1_we),
    .m1_gnt   (m1_gnt),
    .m1_dout  (m1_dout),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_din;
  end
  assign mem_dout = mem[mem_addr[7:0]];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    m0_req = 1'b1; m0_addr = 16'h0010; m0_din = 16'h0A0A; m0_we = 1'b1;
    m1_req = 1'b1; m1_addr = 16'h00F0; m1_din = 16'h0B0B; m1_we = 1'b1;

    // reset held two cycles with both masters requesting
    cyc();
    chk("rst1_m0_gnt", m0_gnt, 0);
    chk("rst1_m1_gnt", m1_gnt, 0);
    chk("rst1_mem_we", mem_we, 0);
    cyc();
    chk("rst2_m0_gnt", m0_gnt, 0);
    chk("rst2_m1_gnt", m1_gnt, 0);
    chk("rst2_mem_we", mem_we, 0);
    chk("rst2_mem_addr", mem_addr, 0);
    chk("rst2_mem_din", mem_din, 0);
    m0_we = 1'b0; m1_we = 1'b0;
    reset = 1'b0;
    cyc();
    chk("first_tie_m0_gnt", m0_gnt, 1);
    chk("first_tie_m1_gnt", m1_gnt, 0);
    chk("first_tie_addr", mem_addr, 16'h0010);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();
    chk("idle_m0_gnt", m0_gnt, 0);
    chk("idle_addr", mem_addr, 0);

    // single master write then read-back
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h00F0; m1_din = 16'hBEEF;
    cyc();
    chk("wr_m1_gnt", m1_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 16'h00F0);
    chk("wr_mem_din", mem_din, 16'hBEEF);
    cyc();
    m1_we = 1'b0;
    #1;
    chk("rd_m1_dout", m1_dout, 16'hBEEF);
    chk("rd_mem_we", mem_we, 0);
    m1_req = 1'b0;
    cyc();
    chk("wr_release_idle", dut.state, ST_IDLE);

    // tie from idle, zero-gap handover, round-robin
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0010; m0_we = 1'b0;
    cyc();
    chk("tie_m0_gnt", m0_gnt, 1);
    cyc();
    cyc();
    chk("tie_hold3_m0_gnt", m0_gnt, 1);
    chk("tie_hold3_m1_gnt", m1_gnt, 0);
    m0_req = 1'b0;
    cyc();
    chk("handover_m1_gnt", m1_gnt, 1);
    chk("handover_m0_gnt", m0_gnt, 0);
    chk("handover_addr", mem_addr, 16'h00F0);
    m0_req = 1'b1; m1_req = 1'b0;
    cyc();
    chk("rr_back_m0_gnt", m0_gnt, 1);
    m0_req = 1'b0;
    cyc();
    chk("rr_idle_state", dut.state, ST_IDLE);
    m0_req = 1'b1; m1_req = 1'b1;
    cyc();
    chk("rr_tie_m1_gnt", m1_gnt, 1);
    chk("rr_tie_m0_gnt", m0_gnt, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();

    // release masking: req low with we high must not write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0020; m0_din = 16'h1111;
    cyc();
    chk("mask_wr_mem_we", mem_we, 1);
    cyc();
    m0_req = 1'b0; m0_din = 16'h2222;
    #1;
    chk("mask_rel_mem_we", mem_we, 0);
    chk("mask_rel_m0_gnt", m0_gnt, 1);
    cyc();
    m0_we = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0020;
    cyc();
    chk("mask_readback", m1_dout, 16'h1111);
    m1_req = 1'b0;
    cyc();

    // hold limit: m0 keeps req while m1 waits
    m0_req = 1'b1; m0_addr = 16'h0030;
    cyc();
    chk("hold_start_m0_gnt", m0_gnt, 1);
    m1_req = 1'b1;
    n = 1;
    for (int i = 0; i < 99; i++) begin
      cyc();
      if (!m0_gnt) break;
      n++;
    end
`ifdef ARB_HOLD_LIMIT_EN
    chk("hold_m0_cycles", n, 4);
    chk("hold_preempt_m1_gnt", m1_gnt, 1);
`else
    chk("hold_m0_cycles", n, 100);
    chk("hold_no_preempt_m1_gnt", m1_gnt, 0);
`endif
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();
    chk("hold_release_idle", dut.state, ST_IDLE);

    // reset mid-transfer while master 1 owns the bus
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h00F0; m1_din = 16'h5555;
    cyc();
    chk("midrst_own1", m1_gnt, 1);
    reset = 1'b1;
    cyc();
    chk("midrst_m1_gnt", m1_gnt, 0);
    chk("midrst_m0_gnt", m0_gnt, 0);
    chk("midrst_state", dut.state, ST_IDLE);
    chk("midrst_mem_we", mem_we, 0);
    reset = 1'b0;
    m1_we = 1'b0;
    cyc();
    chk("post_rst_m1_gnt", m1_gnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter that shares the 16-bit memory/IO bus (`memory_map`) between the processor and a second bus master such as a program loader or debug port. It sits between the masters and `memory_map` in the system top level. It grants ownership with a registered round-robin FSM. An optional hold-limit counter bounds how long one master can keep the bus.

## Interface

Parameters:
- `AW`, 16, address width.
- `DW`, 16, data width.
- `MAX_HOLD`, 16, maximum consecutive owned cycles before forced handover when the other master waits. Range 1–255. Used only with `ARB_HOLD_LIMIT_EN`.

Ports:
- `clk`  in  1  system clock. The block uses one clock.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req`  in  1  master 0 (processor) bus request.
- `m0_addr`  in  AW  master 0 address.
- `m0_din`  in  DW  master 0 write data.
- `m0_we`  in  1  master 0 write enable.
- `m0_gnt`  out  1  master 0 owns the bus this cycle.
- `m0_dout`  out  DW  read data to master 0.
- `m1_req`, `m1_addr`, `m1_din`, `m1_we`, `m1_gnt`, `m1_dout`: same as the master 0 ports, for master 1 (loader).
- `mem_addr`  out  AW  address to `memory_map`.
- `mem_din`  out  DW  write data to `memory_map`.
- `mem_we`  out  1  write enable to `memory_map`.
- `mem_dout`  in  DW  read data from `memory_map`.

## Operation

- FSM states:
  - IDLE: no owner.
  - OWN0: master 0 owns the bus.
  - OWN1: master 1 owns the bus.
- `last` register: the most recently served master. Reset value 1, so master 0 wins the first tie.
- Transitions, evaluated at every posedge:
  - IDLE: exactly one requester → that requester's OWN state. Both requesting → the master that is not `last`. None → stay in IDLE.
  - OWNx, owner's `req` high, not preempted → stay in OWNx.
  - OWNx, owner's `req` low → OWNy if the other master requests, else IDLE. `last` ← x.
  - OWNx, preempted (hold limit reached and the other master requesting) → OWNy. `last` ← x.
- `mX_gnt` = (state == OWNX). Grants are registered, mutually exclusive, and never both high.
- Bus mux:
  - `mem_addr` and `mem_din` come from the owner. In IDLE they are 0.
  - `mem_we` = owner `we` & owner `req` & owner `gnt`. A released master cannot write.
- `mem_dout` is broadcast combinationally to `m0_dout` and `m1_dout`. Only the owner may consume it.
- A transfer completes on any posedge where `gnt` & `req` are both high for that master. A master with `req` high and `gnt` low holds its address, data and `we` stable.
- Reset mid-operation: the next posedge forces IDLE and drops both grants. Any write in that cycle is not guaranteed.

## Timing

- Grant latency from IDLE: 1 cycle. `req` rises in cycle N; `gnt` is high in cycle N+1.
- Handover has zero dead cycles. The owner drops `req` in cycle N while the other master requests; the other master's `gnt` is high in cycle N+1.
- `mem_*` outputs follow the registered state combinationally in the same cycle as `gnt`.
- Reset values: state IDLE, `m0_gnt` = `m1_gnt` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_din` = 0, `last` = 1, `hold_cnt` = 0.

## Configuration

- Macro: `ARB_HOLD_LIMIT_EN`.
- Defined:
  - 8-bit `hold_cnt` resets to 0 on every ownership change and increments each owned cycle, saturating.
  - When `hold_cnt` == `MAX_HOLD`-1 and the other master requests, the next edge hands over the bus.
  - The preempted master keeps `req` high and regains the bus through normal round-robin.
- Undefined: no counter and no preemption. An owner keeps the bus until it drops `req`.

## Structure

- Shared package `bus_pkg`:
  - state encodings IDLE/OWN0/OWN1.
  - master index constants.
  - `AW`/`DW` defaults.
  - hold-counter width.
- One sub-module, `arb_hold_counter`: the saturating counter and its expiry compare, instantiated only under `ARB_HOLD_LIMIT_EN`. The FSM and mux stay in `bus_arbiter`.

## Test plan

- **Reset:** assert `reset` for 2 cycles with both `req` high → both `gnt` 0 and `mem_we` 0 during reset. First grant after release goes to `m0`.
- **Single master write:** `m1_req`=1, `m1_we`=1, `m1_addr`=0x00F0, `m1_din`=0xBEEF → `m1_gnt` high next cycle, `mem_we`=1 with `mem_addr`=0x00F0, and a read-back shows 0xBEEF.
- **Tie and round-robin:** both request from IDLE → `m0` granted. `m0` drops `req` after 3 cycles → `m1_gnt` high on the very next cycle with no IDLE gap. Both re-request after `m1` releases → `m0` granted.
- **Release masking:** `m0` drops `req` while keeping `we`=1 → `mem_we`=0 that cycle and no write occurs.
- **Hold limit:** with `ARB_HOLD_LIMIT_EN` and `MAX_HOLD`=4, `m0` holds `req`, `m1` requests → `m0_gnt` lasts exactly 4 cycles, then `m1_gnt`. Without the macro, `m0_gnt` persists for 100 cycles.
- **Reset mid-transfer:** assert `reset` while OWN1 → `m1_gnt` is 0 the cycle after the reset edge and the state is IDLE.
